mem_port_arbiter: RTL

//  Shares one single-port memory between instruction fetch (IF) and execute-stage load/store (DM) requests.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arb_tag_fifo.sv | 53 +++++
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/DM memory port arbiter.
// Tag encoding, FSM states and memory-width constants.
package mem_arb_pkg;

    typedef enum logic {
        TAG_IF = 1'b0,
        TAG_DM = 1'b1
    } tag_t;

    typedef enum logic [1:0] {
        ARB     = 2'd0,
        HOLD_IF = 2'd1,
        HOLD_DM = 2'd2
    } arb_state_t;

    localparam int          WIDTH_W    = 2;
    localparam logic [1:0] WIDTH_BYTE = 2'd0;
    localparam logic [1:0] WIDTH_HALF = 2'd1;
    localparam logic [1:0] WIDTH_WORD = 2'd2;

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// In-order tag queue: remembers which requester owns each
// outstanding memory access so responses can be routed back.
module mem_arb_tag_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  tag_t din,
    input  logic pop,
    output tag_t dout,
    output logic full,
    output logic empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    tag_t          slots [DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic [PW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt_q == (PW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = slots[rd_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) slots[i] <= TAG_IF;
        end else begin
            if (do_push) begin
                slots[wr_q] <= din;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) rd_q <= rd_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch (IF) and load/store (DM).
// Define FAIR_ARB_EN to bound IF starvation with a loss counter.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int OUT_DEPTH    = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req_valid,
    output logic               if_req_ready,
    input  logic [AW-1:0]      if_addr,
    output logic               if_rsp_valid,
    output logic [DW-1:0]      if_rsp_data,
    input  logic               dm_req_valid,
    output logic               dm_req_ready,
    input  logic [AW-1:0]      dm_addr,
    input  logic [DW-1:0]      dm_wdata,
    input  logic               dm_write,
    input  logic [WIDTH_W-1:0] dm_width,
    output logic               dm_rsp_valid,
    output logic [DW-1:0]      dm_rsp_data,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    output logic               mem_write,
    output logic [WIDTH_W-1:0] mem_width,
    input  logic               mem_rsp_valid,
    input  logic [DW-1:0]      mem_rsp_data
);

    arb_state_t state_q;
    arb_state_t state_d;
    logic       sel_dm;
    logic       req_v;
    logic       hs;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    tag_t       fifo_head;
    logic       starved;

`ifdef FAIR_ARB_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] starve_q;

    assign starved = (starve_q >= CW'(STARVE_LIMIT));

    // Counts DM wins taken from ARB while fetch was waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else if (req_v && !sel_dm) begin
            starve_q <= '0;
        end else if (state_q == ARB && req_v && if_req_valid && !starved) begin
            starve_q <= starve_q + 1'b1;
        end
    end
`else
    assign starved = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ARB;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB: begin
                if (req_v && !mem_req_ready)
                    state_d = sel_dm ? HOLD_DM : HOLD_IF;
            end
            HOLD_IF,
            HOLD_DM: begin
                if (hs) state_d = ARB;
            end
            default: state_d = ARB;
        endcase
    end

    always_comb begin
        sel_dm = 1'b0;
        unique case (state_q)
            ARB:     sel_dm = dm_req_valid & ~(starved & if_req_valid);
            HOLD_IF: sel_dm = 1'b0;
            HOLD_DM: sel_dm = 1'b1;
            default: sel_dm = 1'b0;
        endcase
    end

    // A full tag queue blocks the grant even if a pop lands this cycle.
    assign req_v = (sel_dm ? dm_req_valid : if_req_valid) & ~fifo_full & ~rst;
    assign hs    = req_v & mem_req_ready;

    assign mem_req_valid = req_v;
    assign if_req_ready  = ~sel_dm & mem_req_ready & ~fifo_full & ~rst;
    assign dm_req_ready  =  sel_dm & mem_req_ready & ~fifo_full & ~rst;
    assign mem_addr      = sel_dm ? dm_addr : if_addr;
    assign mem_wdata     = sel_dm ? dm_wdata : '0;
    assign mem_write     = sel_dm & dm_write;
    assign mem_width     = sel_dm ? dm_width : WIDTH_WORD;

    assign pop          = mem_rsp_valid & ~fifo_empty & ~rst;
    assign if_rsp_valid = pop & (fifo_head == TAG_IF);
    assign dm_rsp_valid = pop & (fifo_head == TAG_DM);
    assign if_rsp_data  = mem_rsp_data;
    assign dm_rsp_data  = mem_rsp_data;

    mem_arb_tag_fifo #(
        .DEPTH (OUT_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (hs),
        .din   (sel_dm ? TAG_DM : TAG_IF),
        .pop   (pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always @(posedge clk) begin
        if (!rst) begin
            assert (STARVE_LIMIT > 0)
                else $warning("mem_arb: STARVE_LIMIT must be positive");
            assert (!(mem_rsp_valid && fifo_empty))
                else $warning("mem_arb: response with nothing outstanding dropped");
        end
    end

endmodule
